// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one full-adder cell plus a carry flop reused
// every clock, operands consumed LSB first. A start/done handshake lets a
// controlling FSM sequence it; busy is high while bits are being processed.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input, which turns
// the operation into a - b (B inverted, initial carry forced to 1).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cOut
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT            state;
    stateT            stateNext;
    logic [WIDTH-1:0] aSh;
    logic [WIDTH-1:0] bSh;
    logic [WIDTH-1:0] pSum;
    logic [WIDTH-1:0] pSumNext;
    logic [WIDTH-1:0] bLoad;
    logic             cLoad;
    logic             carry;
    logic             sBit;
    logic             cBit;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic             last;

    // Operand conditioning at load time: subtract is a + ~b + 1.
`ifdef SERIAL_ADDER_SUB_EN
    assign bLoad = sub ? ~b : b;
    assign cLoad = sub ? 1'b1 : cIn;
`else
    assign bLoad = b;
    assign cLoad = cIn;
`endif

    // The single full-adder cell working on the current LSBs.
    assign sBit = aSh[0] ^ bSh[0] ^ carry;
    assign cBit = (aSh[0] & bSh[0]) | (aSh[0] & carry) | (bSh[0] & carry);

    // New sum bit enters at the MSB so the finished word is aligned after WIDTH shifts.
    assign pSumNext = (pSum >> 1) | (WIDTH'(sBit) << (WIDTH - 1));

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        stateNext = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    last      = 1'b1;
                    stateNext = DONE;
                end
            end
            DONE: begin
                // A start here begins the next operation with no idle gap.
                if (start) begin
                    load      = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Shift registers, carry, bit counter and the held result.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            aSh   <= '0;
            bSh   <= '0;
            pSum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cOut  <= 1'b0;
        end else if (load) begin
            aSh   <= a;
            bSh   <= bLoad;
            pSum  <= '0;
            carry <= cLoad;
            cnt   <= '0;
        end else if (step) begin
            aSh   <= aSh >> 1;
            bSh   <= bSh >> 1;
            pSum  <= pSumNext;
            carry <= cBit;
            cnt   <= cnt + CNT_W'(1);
            // Result outputs move only on the completion edge.
            if (last) begin
                sum  <= pSumNext;
                cOut <= cBit;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: three instances (WIDTH 8, 3, 1) share
// operands but have separate start lines. Stimulus pushes expected results
// computed with plain arithmetic; a negedge monitor pops and compares.
module tb_serial_adder;

`ifdef SERIAL_ADDER_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstN;
    logic [2:0] start;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic       cIn;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif

    logic       busy8, busy3, busy1;
    logic       done8, done3, done1;
    logic       cOut8, cOut3, cOut1;
    logic [7:0] sum8;
    logic [2:0] sum3;
    logic [0:0] sum1;

    logic [2:0] busyV;
    logic [2:0] doneV;
    logic [2:0] cOutV;
    logic [7:0] sumV [3];

    assign busyV   = {busy1, busy3, busy8};
    assign doneV   = {done1, done3, done8};
    assign cOutV   = {cOut1, cOut3, cOut8};
    assign sumV[0] = sum8;
    assign sumV[1] = {5'b0, sum3};
    assign sumV[2] = {7'b0, sum1};

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rstN(rstN), .start(start[0]), .a(aIn), .b(bIn), .cIn(cIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cOut(cOut8)
    );

    serial_adder #(.WIDTH(3)) u3 (
        .clk(clk), .rstN(rstN), .start(start[1]), .a(aIn[2:0]), .b(bIn[2:0]), .cIn(cIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy3), .done(done3), .sum(sum3), .cOut(cOut3)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk(clk), .rstN(rstN), .start(start[2]), .a(aIn[0:0]), .b(bIn[0:0]), .cIn(cIn),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cOut(cOut1)
    );

    typedef struct {
        int         inst;
        logic [7:0] s;
        logic       co;
        int         st;   // cycle count when start was driven
        int         cyc;  // cycle count at which done must be seen
    } expT;

    expT        q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         lastDone [3];
    logic [7:0] held [3];
    logic       heldC [3];

    function automatic int widthOf(input int i);
        return (i == 0) ? 8 : ((i == 1) ? 3 : 1);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Drive one cycle of stimulus (called at a negedge) and record every start
    // the adder will accept: it is free once the previous done cycle is reached.
    task automatic step(input logic [2:0] st, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb);
        start = st;
        aIn   = av;
        bIn   = bv;
        cIn   = ci;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = sb;
`endif
        for (int i = 0; i < 3; i++) begin
            if (st[i] && cyc >= lastDone[i]) begin
                int              w;
                longint unsigned m, bEff, cEff, tot;
                expT             e;
                w    = widthOf(i);
                m    = (64'd1 << w) - 1;
                bEff = (SUB_EN && sb) ? (~longint'(bv) & m) : (longint'(bv) & m);
                cEff = (SUB_EN && sb) ? 64'd1 : longint'(ci);
                tot  = (longint'(av) & m) + bEff + cEff;
                e.inst = i;
                e.s    = 8'(tot & m);
                e.co   = tot[w];
                e.st   = cyc;
                e.cyc  = cyc + 1 + w;
                lastDone[i] = e.cyc;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(3'b000, aIn, bIn, 1'b0, 1'b0);
    endtask

    task automatic checkResetOutputs();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busyV[i] !== 1'b0 || doneV[i] !== 1'b0 || sumV[i] !== 8'h00 || cOutV[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset[%0d]: busy=%b done=%b sum=%h cOut=%b, want all zero",
                         i, busyV[i], doneV[i], sumV[i], cOutV[i]);
            end
        end
    endtask

    task automatic modelReset();
        q.delete();
        for (int i = 0; i < 3; i++) begin
            lastDone[i] = -1;
            held[i]     = 8'h00;
            heldC[i]    = 1'b0;
        end
    endtask

    // Monitor: compares done/result/timing, held outputs and busy each cycle.
    always @(negedge clk) begin
        if (rstN) begin
            for (int i = 0; i < 3; i++) begin
                int   idx;
                logic expBusy;
                idx = -1;
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k].inst == i) begin
                        idx = k;
                        break;
                    end
                end
                vectors++;
                if (doneV[i]) begin
                    if (idx < 0) begin
                        miscompares++;
                        $display("FAIL spurious_done[%0d] at cyc %0d: sum=%h cOut=%b, no result expected",
                                 i, cyc, sumV[i], cOutV[i]);
                    end else begin
                        expT e;
                        e = q[idx];
                        q.delete(idx);
                        if (sumV[i] !== e.s || cOutV[i] !== e.co || cyc != e.cyc || busyV[i] !== 1'b0) begin
                            miscompares++;
                            $display("FAIL result[%0d]: sum=%h cOut=%b cyc=%0d busy=%b, want sum=%h cOut=%b cyc=%0d busy=0",
                                     i, sumV[i], cOutV[i], cyc, busyV[i], e.s, e.co, e.cyc);
                        end
                        held[i]  = e.s;
                        heldC[i] = e.co;
                    end
                end else if (sumV[i] !== held[i] || cOutV[i] !== heldC[i]) begin
                    miscompares++;
                    $display("FAIL held[%0d] at cyc %0d: sum=%h cOut=%b, want sum=%h cOut=%b",
                             i, cyc, sumV[i], cOutV[i], held[i], heldC[i]);
                end
                expBusy = 1'b0;
                foreach (q[k]) if (q[k].inst == i && q[k].st < cyc && q[k].cyc > cyc) expBusy = 1'b1;
                vectors++;
                if (busyV[i] !== expBusy) begin
                    miscompares++;
                    $display("FAIL busy[%0d] at cyc %0d: got %b, want %b", i, cyc, busyV[i], expBusy);
                end
            end
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].cyc < cyc) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_done[%0d]: no done by cyc %0d, want at cyc %0d sum=%h cOut=%b",
                             q[k].inst, cyc, q[k].cyc, q[k].s, q[k].co);
                    q.delete(k);
                end
            end
        end
    end

    initial begin
        start = 3'b000;
        aIn   = 8'h00;
        bIn   = 8'h00;
        cIn   = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        modelReset();
        rstN = 1'b1;
        #2 rstN = 1'b0;
        #1 checkResetOutputs();
        @(negedge clk);
        rstN = 1'b1;
        idle(2);

        // Simple add, then latency/held checks.
        step(3'b001, 8'h0F, 8'h01, 1'b0, 1'b0);
        idle(10);

        // Start held high across two operations; the mid-run starts are ignored.
        step(3'b001, 8'hFF, 8'h01, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) step(3'b001, 8'h80, 8'h80, 1'b0, 1'b0);
        idle(12);

        // Single start pulse during RUN must be ignored.
        step(3'b001, 8'h11, 8'h22, 1'b0, 1'b0);
        idle(2);
        step(3'b001, 8'hAA, 8'hBB, 1'b1, 1'b0);
        idle(10);

        // Asynchronous reset in the middle of an operation.
        step(3'b001, 8'h12, 8'h34, 1'b0, 1'b0);
        idle(3);
        #2 rstN = 1'b0;
        #1 checkResetOutputs();
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        step(3'b001, 8'h55, 8'h0A, 1'b1, 1'b0);
        idle(10);

        // Exhaustive sweeps at WIDTH=3 and WIDTH=1.
        for (int av = 0; av < 8; av++)
            for (int bv = 0; bv < 8; bv++)
                for (int c = 0; c < 2; c++) begin
                    step(3'b010, 8'(av), 8'(bv), c[0], 1'b0);
                    idle(3);
                end
        for (int av = 0; av < 2; av++)
            for (int bv = 0; bv < 2; bv++)
                for (int c = 0; c < 2; c++) begin
                    step(3'b100, 8'(av), 8'(bv), c[0], 1'b0);
                    idle(1);
                end

        // Subtraction cases.
        if (SUB_EN) begin
            step(3'b001, 8'h05, 8'h07, 1'b0, 1'b1);
            idle(10);
            step(3'b001, 8'h07, 8'h05, 1'b1, 1'b1);
            idle(10);
        end

        // Random traffic on all three instances.
        for (int k = 0; k < 400; k++) begin
            logic [2:0] st;
            st = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
            step(st, 8'($urandom), 8'($urandom), 1'($urandom), SUB_EN ? 1'($urandom) : 1'b0);
        end
        idle(14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

- Parametrised bit-serial adder.
- Adds two WIDTH-bit operands plus a carry-in, one bit per clock, least-significant bit first.
- A single full-adder cell and a carry flip-flop are reused every cycle.
- Sits beside the combinational adders as the area-minimal option for wide operands; a start/done handshake lets a controlling FSM sequence it.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.

Ports:
- clk  input  1  single clock, rising-edge.
- rstN  input  1  reset; asynchronous assert, active-low.
- start  input  1  request a new operation; sampled on rising clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cIn  input  1  carry-in; sampled only on an accepted start.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when sum/cOut are updated.
- sum  output  WIDTH  registered result, held between operations.
- cOut  output  1  registered carry-out of bit WIDTH-1, held between operations.

## Operation
States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → latch a, b, cIn into shift registers and the carry flop.
  - Clear the bit counter; go to RUN.
- RUN, every cycle:
  - Compute s = aSh[0] ^ bSh[0] ^ carry.
  - Compute c = majority(aSh[0], bSh[0], carry).
  - Shift aSh and bSh right by one.
  - Shift s into the MSB of the partial-sum register.
  - carry ← c; counter increments.
- RUN exit:
  - After the WIDTH-th bit: copy the partial sum to sum and the final carry to cOut.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - start=1 → behaves as start in IDLE (back-to-back operation).
  - Otherwise go to IDLE.
- start while in RUN: ignored; operands are not re-sampled and there is no error flag.
- Arithmetic:
  - {cOut, sum} = a + b + cIn, modulo 2^(WIDTH+1).
  - Unsigned; no overflow flag.
- sum and cOut change only on the completion edge, never mid-operation.
- Counter width: $clog2(WIDTH+1) bits.
- WIDTH=1: RUN lasts one cycle.

## Timing
- Reset (rstN=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cOut=0.
  - Internal shift registers, carry and counter are cleared.
  - Reset mid-RUN abandons the operation; the previous sum/cOut are lost (zeroed).
- Start accepted on edge E0:
  - busy=1 from E0 until E(WIDTH).
  - Bits are processed on edges E1..E(WIDTH).
  - sum, cOut and done=1 are valid after E(WIDTH).
- Latency: start edge to done = WIDTH cycles. busy=0 in the DONE cycle.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- Release of rstN takes effect on the following clk edge; start on that same edge is accepted.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - Adds the sub input, sampled with the operands.
  - sub=1 → the latched B is ~b and the initial carry is 1, giving {cOut, sum} = a + ~b + 1; cIn is ignored.
  - cOut=1 means no borrow (a ≥ b).
  - sub=0 → add as normal.
- SERIAL_ADDER_SUB_EN undefined:
  - No sub port; add only.
  - Logic is identical to the sub=0 case.

## Test plan
- WIDTH=8: a=8'h0F, b=8'h01, cIn=0, start pulse → done exactly 8 cycles after the start edge; sum=8'h10, cOut=0; busy low in the done cycle.
- WIDTH=8: a=8'hFF, b=8'h01, cIn=1 → sum=8'h01, cOut=1. Then start held high across two operations (a=8'h80, b=8'h80, cIn=0 second) → second result sum=8'h00, cOut=1, done again 9 cycles after the first done.
- Start pulsed at cycle 3 of RUN with different operands → ignored; the original result is returned at the original time; exactly one done pulse.
- rstN driven low at cycle 4 of RUN → busy, done, sum, cOut go to 0 immediately without a clock edge; a new start after release completes normally.
- Exhaustive sweep at WIDTH=1 and WIDTH=3: every a, b, cIn combination compared against the reference sum, each with latency WIDTH.
- With SERIAL_ADDER_SUB_EN, WIDTH=8:
  - a=8'h05, b=8'h07, sub=1 → sum=8'hFE, cOut=0.
  - a=8'h07, b=8'h05, sub=1 → sum=8'h02, cOut=1.
